// File: rtl/tmvp_operand_server_if.sv
// Operand server bus: load stream, dual-port read requests/data and result beats.
interface tmvp_operand_server_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned AW         = 10
);
  logic [DATA_WIDTH-1:0] s_load_tdata;
  logic                  s_load_tvalid;
  logic                  s_load_tlast;
  logic                  s_load_tready;

  logic [AW-1:0]         address_1;
  logic                  address_1_isRow;
  logic [AW-1:0]         address_2;
  logic                  address_2_isRow;
  logic                  address_valid;
  logic [AW-1:0]         address_vec_1;
  logic [AW-1:0]         address_vec_2;
  logic                  address_vec_valid;

  logic [DATA_WIDTH-1:0] data_row_data_1;
  logic [DATA_WIDTH-1:0] data_row_data_2;
  logic                  data_row_valid;
  logic [DATA_WIDTH-1:0] data_vec_data_1;
  logic [DATA_WIDTH-1:0] data_vec_data_2;
  logic                  data_vec_valid;

  logic                  res_tvalid;

  // Server side
  modport slave (
    input  s_load_tdata, s_load_tvalid, s_load_tlast,
    output s_load_tready,
    input  address_1, address_1_isRow, address_2, address_2_isRow, address_valid,
    input  address_vec_1, address_vec_2, address_vec_valid,
    output data_row_data_1, data_row_data_2, data_row_valid,
    output data_vec_data_1, data_vec_data_2, data_vec_valid,
    input  res_tvalid
  );

  // Loader / multiplier side
  modport master (
    output s_load_tdata, s_load_tvalid, s_load_tlast,
    input  s_load_tready,
    output address_1, address_1_isRow, address_2, address_2_isRow, address_valid,
    output address_vec_1, address_vec_2, address_vec_valid,
    input  data_row_data_1, data_row_data_2, data_row_valid,
    input  data_vec_data_1, data_vec_data_2, data_vec_valid,
    output res_tvalid
  );
endinterface

// File: rtl/tmvp_operand_server.sv
// Memory-side responder for the Toeplitz matrix-vector multiplier: loads three
// operand banks, kicks the multiplier, serves its reads and counts its results.
module tmvp_operand_server #(
  parameter int unsigned N          = 864,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  tmvp_operand_server_if.slave  bus,
  output logic                  mm_start,
  output logic                  busy,
  output logic                  done,
  output logic                  load_error
);
  localparam int unsigned AW        = $clog2(N);
  localparam int unsigned LW        = 12;
  localparam int unsigned RW        = $clog2(N + 1);
  localparam int unsigned LAST_BEAT = 3 * N - 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, SERVE, DONE} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [LW-1:0]         load_cnt;
  logic [RW-1:0]         res_cnt;

  logic [DATA_WIDTH-1:0] row_mem [N];
  logic [DATA_WIDTH-1:0] col_mem [N];
  logic [DATA_WIDTH-1:0] vec_mem [N];

  logic                  load_fire;
  logic                  last_beat;
  logic                  tlast_bad;
  logic                  serving;
  logic [DATA_WIDTH-1:0] rd_row_1;
  logic [DATA_WIDTH-1:0] rd_row_2;
  logic [DATA_WIDTH-1:0] rd_vec_1;
  logic [DATA_WIDTH-1:0] rd_vec_2;

  assign load_fire = bus.s_load_tvalid && bus.s_load_tready;
  assign last_beat = (load_cnt == LW'(LAST_BEAT));
  assign tlast_bad = last_beat ? !bus.s_load_tlast : bus.s_load_tlast;
  assign serving   = (state_q == SERVE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_fire) state_d = LOAD;
      LOAD:    if (load_fire && last_beat) state_d = START;
      START:   state_d = SERVE;
      SERVE:   if (bus.res_tvalid && (res_cnt == RW'(N - 1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.s_load_tready <= 1'b1;
      mm_start          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      bus.s_load_tready <= (state_d == IDLE) || (state_d == LOAD);
      mm_start          <= (state_d == START);
      busy              <= (state_d != IDLE);
      done              <= (state_d == DONE);
    end
  end

  // Load/result counters and sticky tlast-placement error (cleared by a new load)
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt   <= '0;
      res_cnt    <= '0;
      load_error <= 1'b0;
    end else begin
      if (load_fire) begin
        load_cnt   <= last_beat ? '0 : load_cnt + LW'(1);
        load_error <= ((state_q == IDLE) ? 1'b0 : load_error) | tlast_bad;
      end
      if (state_q == START)              res_cnt <= '0;
      else if (serving && bus.res_tvalid) res_cnt <= res_cnt + RW'(1);
    end
  end

  // Operand banks; contents survive reset
  always_ff @(posedge clk) begin
    if (load_fire) begin
      if (load_cnt < LW'(N))          row_mem[AW'(load_cnt)]                  <= bus.s_load_tdata;
      else if (load_cnt < LW'(2 * N)) col_mem[AW'(load_cnt - LW'(N))]         <= bus.s_load_tdata;
      else                            vec_mem[AW'(load_cnt - LW'(2 * N))]     <= bus.s_load_tdata;
    end
  end

  // Bank lookups; out-of-range addresses read as zero
  always_comb begin
    rd_row_1 = '0;
    rd_row_2 = '0;
    rd_vec_1 = '0;
    rd_vec_2 = '0;
    if (32'(bus.address_1) < N)
      rd_row_1 = bus.address_1_isRow ? row_mem[bus.address_1] : col_mem[bus.address_1];
    if (32'(bus.address_2) < N)
      rd_row_2 = bus.address_2_isRow ? row_mem[bus.address_2] : col_mem[bus.address_2];
    if (32'(bus.address_vec_1) < N) rd_vec_1 = vec_mem[bus.address_vec_1];
    if (32'(bus.address_vec_2) < N) rd_vec_2 = vec_mem[bus.address_vec_2];
  end

  // Registered read responses; data holds while no request is served
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_row_valid  <= 1'b0;
      bus.data_row_data_1 <= '0;
      bus.data_row_data_2 <= '0;
      bus.data_vec_valid  <= 1'b0;
      bus.data_vec_data_1 <= '0;
      bus.data_vec_data_2 <= '0;
    end else begin
      bus.data_row_valid <= serving && bus.address_valid;
      bus.data_vec_valid <= serving && bus.address_vec_valid;
      if (serving && bus.address_valid) begin
        bus.data_row_data_1 <= rd_row_1;
        bus.data_row_data_2 <= rd_row_2;
      end
      if (serving && bus.address_vec_valid) begin
        bus.data_vec_data_1 <= rd_vec_1;
        bus.data_vec_data_2 <= rd_vec_2;
      end
    end
  end

endmodule

// File: tb/tb_tmvp_operand_server.sv
// Directed bench for tmvp_operand_server: reset, load, dual-port reads, result count.
module tb_tmvp_operand_server;
  localparam int N     = 864;
  localparam int DW    = 4;
  localparam int AW    = 10;
  localparam int BEATS = 3 * N;

  logic clk = 1'b0;
  logic reset;
  logic mm_start, busy, done, load_error;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tmvp_operand_server_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

  tmvp_operand_server #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .mm_start   (mm_start),
    .busy       (busy),
    .done       (done),
    .load_error (load_error)
  );

  typedef struct {
    logic av; int a1; logic r1; int a2; logic r2;
    logic vv; int v1; int v2;
    logic erv; int er1; int er2;
    logic evv; int ev1; int ev2;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] beat_value(input int b);
    if (b < N)          return 4'(b % 16);
    else if (b < 2 * N) return 4'(15 - ((b - N) % 16));
    else                return 4'(((b - 2 * N) * 3) % 16);
  endfunction

  task automatic idle_bus();
    bus.s_load_tdata      = '0;
    bus.s_load_tvalid     = 1'b0;
    bus.s_load_tlast      = 1'b0;
    bus.address_1         = '0;
    bus.address_1_isRow   = 1'b0;
    bus.address_2         = '0;
    bus.address_2_isRow   = 1'b0;
    bus.address_valid     = 1'b0;
    bus.address_vec_1     = '0;
    bus.address_vec_2     = '0;
    bus.address_vec_valid = 1'b0;
    bus.res_tvalid        = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Streams the 3N operand beats; stop_at >= 0 abandons the load before that beat
  task automatic load(input int stop_at, input bit tlast10, input bit tlast_end, input bit exp_err);
    int pulses = 0;
    int stalls = 0;
    for (int b = 0; b < BEATS; b++) begin
      if (b == stop_at) begin
        bus.s_load_tvalid = 1'b0;
        return;
      end
      if (!bus.s_load_tready) stalls++;
      bus.s_load_tdata  = beat_value(b);
      bus.s_load_tvalid = 1'b1;
      bus.s_load_tlast  = (tlast10 && b == 10) || (tlast_end && b == BEATS - 1);
      step();
      if (b == 0) check("load_error_clear_first_beat", load_error, 0);
      if (tlast10 && b == 10) check("load_error_early_tlast", load_error, 1);
      if (b < BEATS - 1 && mm_start) pulses++;
    end
    bus.s_load_tvalid = 1'b0;
    bus.s_load_tlast  = 1'b0;
    check("tready_during_load", stalls, 0);
    check("mm_start_before_last", pulses, 0);
    check("mm_start_after_last", mm_start, 1);
    check("tready_in_start", bus.s_load_tready, 0);
    check("load_error_final", load_error, exp_err);
    step();
    check("mm_start_one_cycle", mm_start, 0);
    check("busy_serve", busy, 1);
  endtask

  // Drives result beats with a gap every third beat; counts any done seen before the end
  task automatic result_beats(input int count, output int early_done);
    early_done = 0;
    for (int i = 0; i < count; i++) begin
      if (i % 3 == 2) begin
        bus.res_tvalid = 1'b0;
        step();
        if (done) early_done++;
      end
      bus.res_tvalid = 1'b1;
      step();
      if (i < count - 1 && done) early_done++;
    end
    bus.res_tvalid = 1'b0;
  endtask

  initial begin
    int early;

    tbl[0] = '{1'b1, 5,   1'b1, 5,   1'b0, 1'b1, 7,    863, 1'b1, 5,  10, 1'b1, 5,  13};
    tbl[1] = '{1'b1, 20,  1'b1, 17,  1'b0, 1'b1, 0,    1,   1'b1, 4,  14, 1'b1, 0,  3};
    tbl[2] = '{1'b1, 863, 1'b0, 100, 1'b1, 1'b1, 10,   11,  1'b1, 0,  4,  1'b1, 14, 1};
    tbl[3] = '{1'b0, 0,   1'b0, 0,   1'b0, 1'b0, 0,    0,   1'b0, 0,  4,  1'b0, 14, 1};
    tbl[4] = '{1'b1, 863, 1'b1, 900, 1'b1, 1'b1, 864,  2,   1'b1, 15, 0,  1'b1, 0,  6};
    tbl[5] = '{1'b1, 0,   1'b0, 0,   1'b1, 1'b0, 0,    0,   1'b1, 15, 0,  1'b0, 0,  6};
    tbl[6] = '{1'b0, 0,   1'b0, 0,   1'b0, 1'b1, 1023, 5,   1'b0, 15, 0,  1'b1, 0,  15};
    tbl[7] = '{1'b0, 0,   1'b0, 0,   1'b0, 1'b0, 0,    0,   1'b0, 15, 0,  1'b0, 0,  15};

    do_reset();
    check("rst_tready", bus.s_load_tready, 1);
    check("rst_busy", busy, 0);
    check("rst_mm_start", mm_start, 0);
    check("rst_done", done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_row_valid", bus.data_row_valid, 0);
    check("rst_vec_valid", bus.data_vec_valid, 0);
    check("rst_row_data_1", bus.data_row_data_1, 0);

    // Reset in the middle of a load
    load(100, 1'b0, 1'b0, 1'b0);
    check("midload_busy", busy, 1);
    do_reset();
    check("midload_rst_tready", bus.s_load_tready, 1);
    check("midload_rst_busy", busy, 0);
    check("midload_rst_mm_start", mm_start, 0);

    // Clean full load, then table-driven reads
    load(-1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      bus.address_valid     = tbl[k].av;
      bus.address_1         = AW'(tbl[k].a1);
      bus.address_1_isRow   = tbl[k].r1;
      bus.address_2         = AW'(tbl[k].a2);
      bus.address_2_isRow   = tbl[k].r2;
      bus.address_vec_valid = tbl[k].vv;
      bus.address_vec_1     = AW'(tbl[k].v1);
      bus.address_vec_2     = AW'(tbl[k].v2);
      step();
      check($sformatf("v%0d_row_valid", k), bus.data_row_valid, tbl[k].erv);
      check($sformatf("v%0d_row_data_1", k), bus.data_row_data_1, tbl[k].er1);
      check($sformatf("v%0d_row_data_2", k), bus.data_row_data_2, tbl[k].er2);
      check($sformatf("v%0d_vec_valid", k), bus.data_vec_valid, tbl[k].evv);
      check($sformatf("v%0d_vec_data_1", k), bus.data_vec_data_1, tbl[k].ev1);
      check($sformatf("v%0d_vec_data_2", k), bus.data_vec_data_2, tbl[k].ev2);
    end
    idle_bus();

    // Reset in the middle of serving
    result_beats(100, early);
    check("midserve_no_done", early, 0);
    do_reset();
    check("midserve_rst_tready", bus.s_load_tready, 1);
    check("midserve_rst_busy", busy, 0);
    check("midserve_rst_done", done, 0);
    check("midserve_rst_row_valid", bus.data_row_valid, 0);

    // Load with a stray tlast at beat 10
    load(-1, 1'b1, 1'b1, 1'b1);
    bus.address_valid   = 1'b1;
    bus.address_1       = AW'(5);
    bus.address_1_isRow = 1'b1;
    bus.address_2       = AW'(863);
    bus.address_2_isRow = 1'b0;
    step();
    bus.address_valid = 1'b0;
    check("reload_row5", bus.data_row_data_1, 5);
    check("reload_col863", bus.data_row_data_2, 0);

    // Full result stream and return to idle
    result_beats(N, early);
    check("serve_no_early_done", early, 0);
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    bus.address_valid     = 1'b1;
    bus.address_vec_valid = 1'b1;
    step();
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_tready", bus.s_load_tready, 1);
    step();
    check("idle_row_req_ignored", bus.data_row_valid, 0);
    check("idle_vec_req_ignored", bus.data_vec_valid, 0);
    idle_bus();

    // New load clears the sticky error; missing final tlast sets it again
    load(-1, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
